// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 add/sub alignment front end.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int GRS_W = 3;
  localparam int BIAS  = 127;
  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;

  localparam int SIG_W = MAN_W + 1;
  localparam int ALN_W = SIG_W + GRS_W;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp32_t;

  // Ordered operands after the magnitude compare, before the shift.
  typedef struct packed {
    logic [EXP_W-1:0] exp_big;
    logic [EXP_W-1:0] diff;
    logic [SIG_W-1:0] sig_big;
    logic [SIG_W-1:0] sig_small;
    logic             sign;
    logic             eff_sub;
    logic             swap;
    logic             nan;
    logic             inf;
  } fp_cmp_t;

  // Aligned pair handed to the significand adder.
  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] man_big;
    logic [ALN_W-1:0] man_small;
    logic             sign;
    logic             eff_sub;
    logic             swap;
    logic             nan;
    logic             inf;
  } fp_align_t;

endpackage

// File: rtl/fp_align_shift.sv
// Combinational right shifter for the smaller significand; bits shifted out
// of the 27-bit window collapse into the sticky LSB.
module fp_align_shift
  import fp_pkg::*;
(
  input  logic [SIG_W-1:0] sig_i,
  input  logic [EXP_W-1:0] diff_i,
  output logic [ALN_W-1:0] man_o
);

  localparam int SH_W = $clog2(ALN_W);

  logic [ALN_W-1:0] ext;
  logic [ALN_W-1:0] shifted;
  logic [ALN_W-1:0] lost_mask;
  logic [SH_W-1:0]  sh;

  always_comb begin
    ext       = {sig_i, {GRS_W{1'b0}}};
    sh        = diff_i[SH_W-1:0];
    shifted   = ext >> sh;
    lost_mask = (ALN_W'(1) << sh) - ALN_W'(1);
    // Beyond the window everything lands in sticky.
    if (diff_i >= EXP_W'(ALN_W)) begin
      man_o = {{(ALN_W-1){1'b0}}, |sig_i};
    end else begin
      man_o = {shifted[ALN_W-1:1], shifted[0] | (|(ext & lost_mask))};
    end
  end

endmodule

// File: rtl/fp_add_align.sv
// FP32 FADD/FSUB operand alignment: 2-stage compare/swap then shift, valid/ready.
// Define FP_ALIGN_SUBNORMAL_EN to align subnormals instead of flushing them to zero.
module fp_add_align #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int GRS_W = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [EXP_W+MAN_W:0]   a_i,
  input  logic [EXP_W+MAN_W:0]   b_i,
  input  logic                   sub_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [EXP_W-1:0]       exp_o,
  output logic [MAN_W:0]         man_big_o,
  output logic [MAN_W+GRS_W:0]   man_small_o,
  output logic                   sign_o,
  output logic                   eff_sub_o,
  output logic                   swap_o,
  output logic                   nan_o,
  output logic                   inf_o
);
  import fp_pkg::*;

  fp32_t            fa, fb;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [SIG_W-1:0] sig_a, sig_b;
  logic             nan_a, nan_b, inf_a, inf_b;
  logic             swap, eff_sub;

  fp_cmp_t   cmp_p0, cmp_p1;
  fp_align_t aln_p1, out_p2;
  logic      vld_p1, vld_p2;
  logic      ld_p1, ld_p2;
  logic [ALN_W-1:0] man_small_p1;

  assign ld_p2   = !vld_p2 || ready_i;
  assign ld_p1   = !vld_p1 || ld_p2;
  assign ready_o = ld_p1;

  // ---- stage 1: unpack, magnitude compare, order operands ----
  always_comb begin
    fa = a_i;
    fb = b_i;
`ifdef FP_ALIGN_SUBNORMAL_EN
    exp_a = (fa.exp == '0) ? EXP_W'(1) : fa.exp;
    exp_b = (fb.exp == '0) ? EXP_W'(1) : fb.exp;
    sig_a = {fa.exp != '0, fa.frac};
    sig_b = {fb.exp != '0, fb.frac};
`else
    exp_a = fa.exp;
    exp_b = fb.exp;
    sig_a = (fa.exp == '0) ? '0 : {1'b1, fa.frac};
    sig_b = (fb.exp == '0) ? '0 : {1'b1, fb.frac};
`endif
    nan_a   = (fa.exp == EXP_MAX) && (fa.frac != '0);
    nan_b   = (fb.exp == EXP_MAX) && (fb.frac != '0);
    inf_a   = (fa.exp == EXP_MAX) && (fa.frac == '0);
    inf_b   = (fb.exp == EXP_MAX) && (fb.frac == '0);
    eff_sub = fa.sign ^ fb.sign ^ sub_i;
    // Equal magnitudes keep A as the big operand.
    swap    = (exp_a < exp_b) || ((exp_a == exp_b) && (sig_b > sig_a));

    cmp_p0.exp_big   = swap ? exp_b : exp_a;
    cmp_p0.diff      = swap ? (exp_b - exp_a) : (exp_a - exp_b);
    cmp_p0.sig_big   = swap ? sig_b : sig_a;
    cmp_p0.sig_small = swap ? sig_a : sig_b;
    cmp_p0.sign      = swap ? (fb.sign ^ sub_i) : fa.sign;
    cmp_p0.eff_sub   = eff_sub;
    cmp_p0.swap      = swap;
    cmp_p0.nan       = nan_a || nan_b || (inf_a && inf_b && eff_sub);
    cmp_p0.inf       = (inf_a || inf_b) && !cmp_p0.nan;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (ld_p1) vld_p1 <= valid_i;
      if (ld_p2) vld_p2 <= vld_p1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ld_p1 && valid_i) cmp_p1 <= cmp_p0;
  end

  // ---- stage 2: align the smaller significand ----
  fp_align_shift u_shift (
    .sig_i  (cmp_p1.sig_small),
    .diff_i (cmp_p1.diff),
    .man_o  (man_small_p1)
  );

  always_comb begin
    aln_p1.exp       = cmp_p1.exp_big;
    aln_p1.man_big   = cmp_p1.sig_big;
    aln_p1.man_small = man_small_p1;
    aln_p1.sign      = cmp_p1.sign;
    aln_p1.eff_sub   = cmp_p1.eff_sub;
    aln_p1.swap      = cmp_p1.swap;
    aln_p1.nan       = cmp_p1.nan;
    aln_p1.inf       = cmp_p1.inf;
  end

  // Output bundle is cleared on reset so downstream never sees stale data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_p2 <= '0;
    end else if (ld_p2 && vld_p1) begin
      out_p2 <= aln_p1;
    end
  end

  // ---- output ----
  assign valid_o     = vld_p2;
  assign exp_o       = out_p2.exp;
  assign man_big_o   = out_p2.man_big;
  assign man_small_o = out_p2.man_small;
  assign sign_o      = out_p2.sign;
  assign eff_sub_o   = out_p2.eff_sub;
  assign swap_o      = out_p2.swap;
  assign nan_o       = out_p2.nan;
  assign inf_o       = out_p2.inf;

endmodule

// File: tb/tb_fp_add_align.sv
// Directed vector bench for fp_add_align (default build, subnormals flushed).
module tb_fp_add_align;
  import fp_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_i, sub_i;
  logic [31:0] a_i, b_i;
  logic        ready_o, valid_o, sign_o, eff_sub_o, swap_o, nan_o, inf_o;
  logic [7:0]  exp_o;
  logic [23:0] man_big_o;
  logic [26:0] man_small_o;

  fp_add_align dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .sub_i(sub_i), .valid_o(valid_o), .ready_i(ready_i),
    .exp_o(exp_o), .man_big_o(man_big_o), .man_small_o(man_small_o),
    .sign_o(sign_o), .eff_sub_o(eff_sub_o), .swap_o(swap_o),
    .nan_o(nan_o), .inf_o(inf_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    fp_align_t   ex;
  } vec_t;

  localparam int NV = 14;
  vec_t      vecs [NV];
  fp_align_t got;
  int        checks = 0;
  int        errors = 0;

  assign got = {exp_o, man_big_o, man_small_o, sign_o, eff_sub_o, swap_o, nan_o, inf_o};

  task automatic chk_bit(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, req);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic chk_out(input string nm, input fp_align_t act, input fp_align_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual exp=%h big=%h small=%h s/e/w/n/i=%b%b%b%b%b required exp=%h big=%h small=%h s/e/w/n/i=%b%b%b%b%b",
               nm, act.exp, act.man_big, act.man_small, act.sign, act.eff_sub, act.swap, act.nan, act.inf,
               req.exp, req.man_big, req.man_small, req.sign, req.eff_sub, req.swap, req.nan, req.inf);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    a_i     = v.a;
    b_i     = v.b;
    sub_i   = v.sub;
    valid_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int got_n;
    //                a            b            sub   exp    man_big      man_small     s     e     w     n     i
    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, '{8'h80, 24'h800000, 27'h2000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}};
    vecs[1]  = '{32'h4F800000, 32'h3F800001, 1'b0, '{8'h9F, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{32'h3FC00000, 32'h3FE00000, 1'b1, '{8'h7F, 24'hE00000, 27'h6000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, '{8'hFF, 24'h800000, 27'h4000000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, 1'b0, '{8'hFF, 24'h800000, 27'h4000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[5]  = '{32'h7FC00000, 32'h3F800000, 1'b0, '{8'hFF, 24'hC00000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[6]  = '{32'h40400000, 32'hC0400000, 1'b0, '{8'h80, 24'hC00000, 27'h6000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{32'h42000000, 32'h3F800003, 1'b0, '{8'h84, 24'h800000, 27'h0200001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{32'h4C000000, 32'h3FC00000, 1'b0, '{8'h98, 24'h800000, 27'h0000003, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{32'h4D000000, 32'h3F800000, 1'b0, '{8'h9A, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{32'h3F800000, 32'h00000000, 1'b0, '{8'h7F, 24'h800000, 27'h0000000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[11] = '{32'h3F800000, 32'hC0000000, 1'b0, '{8'h80, 24'h800000, 27'h2000000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[12] = '{32'h00400000, 32'h80000001, 1'b0, '{8'h00, 24'h000000, 27'h0000000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[13] = '{32'h3F800000, 32'hFF800000, 1'b0, '{8'hFF, 24'h800000, 27'h0000001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}};

    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; sub_i = 1'b0;
    a_i = '0; b_i = '0;
    step();
    step();
    chk_bit("reset_valid_o", valid_o, 1'b0);
    chk_bit("reset_ready_o", ready_o, 1'b1);
    chk_out("reset_data", got, '0);
    rst_i = 1'b0;
    step();
    chk_bit("post_reset_valid_o", valid_o, 1'b0);

    // Single transactions, one at a time, no backpressure.
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      step();
      valid_i = 1'b0;
      n = 0;
      while (!valid_o && n < 6) begin
        step();
        n++;
      end
      chk_int($sformatf("latency_v%0d", i), n, 1);
      chk_out($sformatf("vec_%0d", i), got, vecs[i].ex);
    end
    step();
    chk_bit("drained", valid_o, 1'b0);

    // Backpressure: three back-to-back inputs against a stalled output.
    ready_i = 1'b0;
    drive(vecs[0]);
    chk_bit("bp_ready_1", ready_o, 1'b1);
    step();
    drive(vecs[1]);
    chk_bit("bp_ready_2", ready_o, 1'b1);
    step();
    drive(vecs[2]);
    chk_bit("bp_ready_fall", ready_o, 1'b0);
    step();
    chk_bit("bp_stall_valid", valid_o, 1'b1);
    chk_out("bp_stall_hold", got, vecs[0].ex);
    step();
    chk_out("bp_stall_hold2", got, vecs[0].ex);
    ready_i = 1'b1;
    #1;
    chk_bit("bp_ready_release", ready_o, 1'b1);
    got_n = 0;
    for (int k = 0; k < 6; k++) begin
      if (valid_o) begin
        if (got_n < 3) chk_out($sformatf("bp_order_%0d", got_n), got, vecs[got_n].ex);
        got_n++;
      end
      step();
      valid_i = 1'b0;
    end
    chk_int("bp_count", got_n, 3);

    // Reset with both stages occupied.
    ready_i = 1'b0;
    drive(vecs[4]);
    step();
    drive(vecs[5]);
    step();
    valid_i = 1'b0;
    chk_bit("full_ready_low", ready_o, 1'b0);
    rst_i = 1'b1;
    step();
    chk_bit("rst_flush_valid", valid_o, 1'b0);
    chk_bit("rst_flush_ready", ready_o, 1'b1);
    chk_out("rst_flush_data", got, '0);
    rst_i = 1'b0;
    ready_i = 1'b1;
    drive(vecs[2]);
    chk_bit("rst_accept_ready", ready_o, 1'b1);
    step();
    valid_i = 1'b0;
    chk_bit("rst_no_stale", valid_o, 1'b0);
    step();
    chk_bit("rst_new_valid", valid_o, 1'b1);
    chk_out("rst_new_data", got, vecs[2].ex);
    step();
    chk_bit("rst_end_empty", valid_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_add_align.md
Name: fp_add_align

Overview:
- Operand-alignment front end of the single-precision FADD/FSUB datapath.
- Accepts two FP32 operands and an add/subtract select, then orders them by magnitude using the 8-bit exponent compare.
- Right-shifts the smaller significand by the exponent difference, generating guard/round/sticky bits.
- Hands the aligned pair to the significand adder/normaliser stage downstream. It is a 2-stage pipeline with valid/ready flow control.

Parameters:
- EXP_W, 8, exponent width.
- MAN_W, 23, stored fraction width (significand = MAN_W+1 with hidden bit).
- GRS_W, 3, extra low-order bits (guard, round, sticky) on the aligned significand.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  input operands valid.
- ready_o  out  1  stage can accept input this cycle.
- a_i  in  32  operand A (FP32).
- b_i  in  32  operand B (FP32).
- sub_i  in  1  1 = A-B, 0 = A+B.
- valid_o  out  1  aligned result valid.
- ready_i  in  1  downstream accepts result.
- exp_o  out  8  larger (common) exponent.
- man_big_o  out  24  larger-magnitude significand, hidden bit included.
- man_small_o  out  27  smaller significand, aligned, {sig, G, R, S}.
- sign_o  out  1  sign of the larger-magnitude operand after applying sub_i.
- eff_sub_o  out  1  effective subtraction (sign_a XOR sign_b XOR sub_i).
- swap_o  out  1  operands were swapped (|B| > |A|).
- nan_o  out  1  result is NaN: either input NaN, or inf - inf effective subtraction.
- inf_o  out  1  result is infinity (and not NaN).

Behaviour:
- Reset:
  - valid_o=0; both internal stage valids=0.
  - All data outputs=0.
  - Reset mid-operation discards all in-flight entries; no output on the cycle after reset deassertion.
- Handshake:
  - Input transfer occurs when valid_i & ready_o.
  - Output transfer occurs when valid_o & ready_i.
  - Each stage register loads when it is empty or its content moves forward in the same cycle.
  - ready_o = !s1_valid | (!s2_valid | ready_i). This is combinational from ready_i; no skid buffer.
  - While stalled, outputs hold stable.
- Latency: 2 cycles from input accept to valid_o with no backpressure. Throughput is 1 per cycle.
- Stage 1 (compare/swap):
  - Unpack sign/exp/fraction; hidden bit = (exp != 0).
  - Magnitude compare: exponent compare first (less/equal/greater); if exponents are equal, compare fractions.
  - |B| > |A| sets swap=1.
  - Register big/small fields, diff = exp_big - exp_small (8-bit, never negative), eff_sub, and special flags.
- Stage 2 (shift):
  - man_small_o = ({sig_small, 3'b000} >> diff).
  - S bit = OR of the sig_small bits shifted past the 27-bit window, OR'ed with the shifted-in LSB.
  - diff >= 27: man_small_o = {26'b0, |sig_small}.
  - diff = 0: no shift.
- sign_o:
  - swap=0: sign_a.
  - swap=1: sign_b XOR sub_i.
  - Equal magnitudes give swap=0.
- Specials:
  - Exponent 0xFF with fraction != 0 is NaN.
  - Exponent 0xFF with fraction 0 is inf.
  - inf_o=1 when any input is inf and nan_o=0.
  - Data fields still propagate per the rules above.
- Zero inputs follow the subnormal rule below.

Optional Feature:
- Macro FP_ALIGN_SUBNORMAL_EN.
  - Defined: exponent-0 operands use effective exponent 1 with hidden bit 0, and are aligned normally.
  - Undefined: exponent-0 operands are flushed to signed zero (fraction forced to 0, hidden bit 0, exponent 0) before compare.

Decomposition:
- Package fp_pkg holds:
  - EXP_W, MAN_W, GRS_W, BIAS=127, EXP_MAX=8'hFF.
  - typedef struct packed fp32_t {sign, exp, frac}.
  - typedef for the aligned-pair bundle.
- Sub-module fp_align_shift: the 27-bit right shifter with sticky collapse, purely combinational, instantiated in stage 2.

Test Plan:
- a=0x3F800000 (1.0), b=0x40000000 (2.0), sub=0 -> after 2 cycles:
  - exp_o=0x80, man_big_o=0x800000, man_small_o=0x2000000.
  - swap_o=1, sign_o=0, eff_sub_o=0.
- a=0x4F800000, b=0x3F800001 (diff 32) -> man_small_o=0x0000001, exp_o=0x9F, swap_o=0.
- a=0x3FC00000 (1.5), b=0x3FE00000 (1.75), sub=1 -> swap_o=1, eff_sub_o=1, sign_o=1, man_big_o=0xE00000, man_small_o=0x6000000.
- Backpressure: ready_i=0, three back-to-back valid_i inputs:
  - ready_o falls after 2 accepts.
  - On releasing ready_i, three outputs emerge in order, unchanged, with no duplicates.
- a=0x7F800000, b=0x7F800000, sub=1 -> nan_o=1, inf_o=0. With sub=0 -> nan_o=0, inf_o=1.
- Reset asserted while both stages are full -> valid_o=0 the next cycle and ready_o=1; the pipeline accepts new input immediately after reset deasserts.
